// File: rtl/pipe_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipe_barrel_shifter
//   Pipelined log-step barrel shifter. A WIDTH-bit word is shifted by 0..WIDTH-1
//   positions through SHW = $clog2(WIDTH) registered stages. Stage k shifts by
//   2^k when its carried shift-amount bit is set. Every stage moves together on
//   a single global advance, so bubbles keep their slots and latency is exactly
//   SHW cycles plus any stall cycles.
//
//   Operations (op):  2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROR
//   Optional feature macro: ROTATE_EN
//     defined     -> op 2'b11 rotates right by shamt
//     not defined -> op 2'b11 behaves exactly like SRL, no rotate logic built
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      din/op/shamt valid
//   in_ready   out  1      block accepts an input this cycle (= global advance)
//   din        in   WIDTH  data to shift
//   shamt      in   SHW    shift amount
//   op         in   2      operation select
//   out_valid  out  1      dout valid (registered)
//   out_ready  in   1      sink accepts dout this cycle
//   dout       out  WIDTH  shifted result (registered)
// -----------------------------------------------------------------------------
module pipe_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout
);

    localparam int SHW = $clog2(WIDTH);
    // Metadata (op, sign, remaining shamt) is only needed by the stages that
    // follow, so the last stage does not store it.
    localparam int MW  = (SHW > 1) ? SHW - 1 : 1;

    logic [SHW-1:0][WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]            valid_q, valid_d;
    logic [MW-1:0][1:0]        op_q, op_d;
    logic [MW-1:0]             sign_q, sign_d;
    logic [MW-1:0][SHW-1:0]    rem_q, rem_d;
    logic                      adv_s;

    // One log step: shift d by a positions according to the operation.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       o,
        input logic             s,
        input int unsigned      a
    );
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            // Sign comes from the captured input MSB, not the current data.
            2'b10:   r = (d >> a) | ({WIDTH{s}} & ~({WIDTH{1'b1}} >> a));
`ifdef ROTATE_EN
            2'b11:   r = (d >> a) | (d << (WIDTH - a));
`else
            2'b11:   r = d >> a;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Whole pipe advances unless a valid result is waiting on the sink.
    assign adv_s     = !valid_q[SHW-1] || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = valid_q[SHW-1];
    assign dout      = data_q[SHW-1];

    // Next-state for every stage: load from predecessor on advance, else hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        op_d    = op_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        if (adv_s) begin
            data_d[0]  = shamt[0] ? step_shift(din, op, din[WIDTH-1], 32'd1) : din;
            valid_d[0] = in_valid;
            if (SHW > 1) begin
                op_d[0]   = op;
                sign_d[0] = din[WIDTH-1];
                rem_d[0]  = shamt >> 1;
            end else begin
                op_d   = op_q;
                sign_d = sign_q;
                rem_d  = rem_q;
            end
            for (int k = 1; k < SHW; k++) begin
                data_d[k]  = rem_q[k-1][0]
                           ? step_shift(data_q[k-1], op_q[k-1], sign_q[k-1], 32'd1 << k)
                           : data_q[k-1];
                valid_d[k] = valid_q[k-1];
                if (k < SHW - 1) begin
                    op_d[k]   = op_q[k-1];
                    sign_d[k] = sign_q[k-1];
                    rem_d[k]  = rem_q[k-1] >> 1;
                end else begin
                    data_d[k] = data_d[k];
                end
            end
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset that drops every in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            op_q    <= '0;
            sign_q  <= '0;
            rem_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
module tb_pipe_barrel_shifter;

    localparam int W  = 8;
    localparam int SH = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  din;
    logic [SH-1:0] shamt;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  dout;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Reference pipeline: SH slots advancing together, each holding the full result.
    bit         mv [SH];
    logic [W-1:0] md [SH];
    logic [W-1:0] got [$];

    pipe_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full-amount shift computed directly from the operation definitions.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] o,
                                               input logic [SH-1:0] s);
        logic [2*W-1:0] t;
        logic [W-1:0]   r;
        case (o)
            2'd0: r = d << s;
            2'd1: r = d >> s;
            2'd2: r = $signed(d) >>> s;
            default: begin
`ifdef ROTATE_EN
                t = {d, d} >> s;
                r = t[W-1:0];
`else
                t = '0;
                r = d >> s;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] d, input logic [1:0] o, input logic [SH-1:0] s);
        bit acc;
        in_valid = 1'b1;
        din      = d;
        op       = o;
        shamt    = s;
        for (int n = 0; n < 50; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    // Per-cycle compare against the reference pipeline, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit adv;
            chk("out_valid", {31'd0, out_valid}, {31'd0, mv[SH-1]});
            if (mv[SH-1]) chk("dout", {24'd0, dout}, {24'd0, md[SH-1]});
            adv = !mv[SH-1] || out_ready;
            chk("in_ready", {31'd0, in_ready}, {31'd0, adv});
            if (out_valid && out_ready && !rst) got.push_back(dout);
            if (rst) begin
                for (int k = 0; k < SH; k++) begin
                    mv[k] = 1'b0;
                    md[k] = '0;
                end
            end else if (adv) begin
                for (int k = SH - 1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    md[k] = md[k-1];
                end
                mv[0] = in_valid;
                md[0] = ref_shift(din, op, shamt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] exp5 [5];
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        rst = 1'b1; in_valid = 1'b0; din = '0; op = '0; shamt = '0; out_ready = 1'b1;
        for (int k = 0; k < SH; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end

        // Pin the reference model with hand-computed values.
        chk("model_sll", {24'd0, ref_shift(8'hB4, 2'd0, 3'd3)}, 32'h000000A0);
        chk("model_srl", {24'd0, ref_shift(8'hB4, 2'd1, 3'd3)}, 32'h00000016);
        chk("model_sra", {24'd0, ref_shift(8'hB4, 2'd2, 3'd3)}, 32'h000000F6);
`ifdef ROTATE_EN
        chk("model_ror", {24'd0, ref_shift(8'hB4, 2'd3, 3'd3)}, 32'h00000096);
`else
        chk("model_ror", {24'd0, ref_shift(8'hB4, 2'd3, 3'd3)}, 32'h00000016);
`endif
        chk("model_sra7", {24'd0, ref_shift(8'h80, 2'd2, 3'd7)}, 32'h000000FF);

        // Reset
        @(posedge clk); #1;
        do_reset(2);
        chk_en = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Four ops back to back on 0xB4 >> 3
        got.delete();
        for (int i = 0; i < 4; i++) issue(8'hB4, 2'(i), 3'd3);
        repeat (6) cyc();
        chk("t2_count", got.size(), 32'd4);
        chk("t2_sll", {24'd0, got[0]}, 32'h000000A0);
        chk("t2_srl", {24'd0, got[1]}, 32'h00000016);
        chk("t2_sra", {24'd0, got[2]}, 32'h000000F6);
`ifdef ROTATE_EN
        chk("t2_ror", {24'd0, got[3]}, 32'h00000096);
`else
        chk("t2_ror_as_srl", {24'd0, got[3]}, 32'h00000016);
`endif

        // shamt = 0 passes data unchanged for every op
        got.delete();
        for (int i = 0; i < 4; i++) issue(8'h5A, 2'(i), 3'd0);
        repeat (6) cyc();
        chk("t3_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_shamt0", {24'd0, got[i]}, 32'h0000005A);

        // Sign fill and extreme amounts
        got.delete();
        issue(8'h80, 2'd2, 3'd7);
        issue(8'h80, 2'd1, 3'd7);
        issue(8'h01, 2'd0, 3'd7);
        repeat (6) cyc();
        chk("t5_count", got.size(), 32'd3);
        chk("t5_sra", {24'd0, got[0]}, 32'h000000FF);
        chk("t5_srl", {24'd0, got[1]}, 32'h00000001);
        chk("t5_sll", {24'd0, got[2]}, 32'h00000080);

        // Backpressure: 4-cycle stall once results start arriving
        got.delete();
        for (int i = 0; i < 5; i++) begin
            exp5[i] = ref_shift(8'h3C + 8'(i * 37), 2'(i % 4), 3'(i + 1));
            issue(8'h3C + 8'(i * 37), 2'(i % 4), 3'(i + 1));
        end
        for (int n = 0; n < 20 && !out_valid; n++) cyc();
        chk("t4_out_valid_seen", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        repeat (4) begin
            #1;
            chk("t4_stall_in_ready", {31'd0, in_ready}, 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("t4_count", got.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk("t4_order", {24'd0, got[i]}, {24'd0, exp5[i]});

        // Reset with two ops in flight
        got.delete();
        issue(8'hC3, 2'd0, 3'd2);
        issue(8'hC3, 2'd2, 3'd5);
        do_reset(1);
        repeat (4) cyc();
        chk("t6_dropped", got.size(), 32'd0);
        issue(8'hC3, 2'd2, 3'd2);
        repeat (5) cyc();
        chk("t6_count", got.size(), 32'd1);
        chk("t6_after", {24'd0, got[0]}, 32'h000000F0);

        // Randomized traffic with random backpressure and rare resets
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            din       = 8'($urandom);
            op        = 2'($urandom);
            shamt     = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) == 0);
            cyc();
        end
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
